midi_msg_rx: RTL and testbench

Parametrised MIDI input block: oversampling serial receiver plus channel-message assembler. Samples the raw MIDI line on the system clock, recovers 8N1 bytes at mid-bit, and assembles status/data bytes into complete channel messages with a one-cycle valid strobe. Sits between the opto-isolated MIDI input pin and the sampler voice logic; also drives the board LEDs with the first data byte of the last accepted message.

---
 rtl/midi_msg_rx.sv | 193 +++++++++++++++++++
 tb/tb_midi_msg_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_rx.sv
// MIDI input: synchroniser, 8N1 oversampling receiver and channel-message assembler.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (keep the last status across messages).
module midi_msg_rx #(
  parameter int CLKS_PER_BIT = 128,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] LED
);

  localparam logic [11:0] HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [11:0] FULL_LAST = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {WAIT_STATUS, WAIT_D1, WAIT_D2} ps_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_p0;
  logic                   rx_p1;

  rx_state_t   rx_state, rx_state_nxt;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        half_hit, full_hit, data_tick, stop_tick, byte_ok, stop_bad;

  ps_state_t   p_state, p_state_nxt;
  logic [7:0]  status_q, status_nxt;
  logic        status_vld, status_vld_nxt;
  logic [7:0]  d1_q, d1_nxt;
  logic        take_d1, emit;
  logic [7:0]  emit_d2;

  // Synchroniser stage: idle-high line, so every flop resets to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      rx_p1  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal};
      rx_p1  <= rx_p0;
    end
  end

  assign rx_p0 = sync_q[SYNC_STAGES-1];

  // Receiver stage
  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nxt;
  end

  always_comb begin
    half_hit  = (cnt == HALF_LAST);
    full_hit  = (cnt == FULL_LAST);
    data_tick = (rx_state == RX_DATA) && full_hit;
    stop_tick = (rx_state == RX_STOP) && full_hit;
    byte_ok   = stop_tick && rx_p0;
    stop_bad  = stop_tick && !rx_p0;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_p1 && !rx_p0) rx_state_nxt = RX_START;
      RX_START: if (half_hit) rx_state_nxt = rx_p0 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (data_tick && bit_idx == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (stop_tick) rx_state_nxt = rx_p0 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_p0) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    busy = (rx_state != RX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (rx_state != rx_state_nxt || rx_state == RX_IDLE || rx_state == RX_BREAK || data_tick)
        cnt <= '0;
      else
        cnt <= cnt + 12'd1;
      if (rx_state == RX_START) bit_idx <= '0;
      else if (data_tick)       bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_tick) shreg <= {rx_p0, shreg[7:1]};
  end

  // Parser stage: consumes the byte on its stop-sample cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state    <= WAIT_STATUS;
      status_q   <= '0;
      status_vld <= 1'b0;
    end else begin
      p_state    <= p_state_nxt;
      status_q   <= status_nxt;
      status_vld <= status_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    d1_q <= d1_nxt;
  end

  always_comb begin
    p_state_nxt    = p_state;
    status_nxt     = status_q;
    status_vld_nxt = status_vld;
    d1_nxt         = d1_q;
    take_d1        = 1'b0;
    emit           = 1'b0;
    emit_d2        = 8'h00;
    if (stop_bad) begin
      p_state_nxt    = WAIT_STATUS;
      status_vld_nxt = 1'b0;
    end else if (byte_ok) begin
      if (shreg[7:3] == 5'b11111) begin
        p_state_nxt = p_state;
      end else if (shreg[7:4] == 4'hF) begin
        status_vld_nxt = 1'b0;
        p_state_nxt    = WAIT_STATUS;
      end else if (shreg[7]) begin
        status_nxt     = shreg;
        status_vld_nxt = 1'b1;
        p_state_nxt    = WAIT_D1;
      end else begin
        case (p_state)
          WAIT_D1: take_d1 = status_vld;
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d2 = shreg;
          end
          default: begin
`ifdef MIDI_RUNNING_STATUS_EN
            take_d1 = status_vld;
`else
            take_d1 = 1'b0;
`endif
          end
        endcase
        if (take_d1) begin
          d1_nxt = shreg;
          if (status_q[7:5] == 3'b110) emit = 1'b1;
          else                         p_state_nxt = WAIT_D2;
        end
        if (emit) begin
          p_state_nxt = WAIT_STATUS;
`ifndef MIDI_RUNNING_STATUS_EN
          status_vld_nxt = 1'b0;
`endif
        end
      end
    end
  end

  // Output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      msg_status <= 8'h00;
      msg_data1  <= 8'h00;
      msg_data2  <= 8'h00;
      LED        <= 8'hFF;
    end else begin
      msg_valid <= emit;
      frame_err <= stop_bad;
      if (emit) begin
        msg_status <= status_q;
        msg_data1  <= d1_nxt;
        msg_data2  <= emit_d2;
        LED        <= d1_nxt;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_rx.sv
// Directed bench for midi_msg_rx with a message scoreboard (CLKS_PER_BIT=16, SYNC_STAGES=2).
module tb_midi_msg_rx;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
  } msg_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       signal = 1'b1;
  logic       msg_valid, frame_err, busy;
  logic [7:0] msg_status, msg_data1, msg_data2, LED;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_ferr = 0;
  int   last_valid_cyc = -1;
  int   last_start = 0;
  int   base;
  msg_t exp_q[$];

  midi_msg_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal),
    .msg_valid(msg_valid), .msg_status(msg_status), .msg_data1(msg_data1),
    .msg_data2(msg_data2), .frame_err(frame_err), .busy(busy), .LED(LED)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop and compare every strobe
  always @(negedge clk) begin
    if (msg_valid || frame_err) chk("valid_ferr_excl", {31'd0, msg_valid & frame_err}, 32'd0);
    if (frame_err) n_ferr++;
    if (msg_valid) begin
      msg_t m;
      n_valid++;
      last_valid_cyc = cyc;
      chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        chk("msg_status", {24'd0, msg_status}, {24'd0, m.st});
        chk("msg_data1", {24'd0, msg_data1}, {24'd0, m.d1});
        chk("msg_data2", {24'd0, msg_data2}, {24'd0, m.d2});
        chk("led", {24'd0, LED}, {24'd0, m.d1});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2;
    exp_q.push_back(m);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    signal = 1'b0;
    last_start = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      signal = b[i];
      wait_cycles(CPB);
    end
    if (stop_low > 0) begin
      signal = 1'b0;
      wait_cycles(24);
      chk("busy_in_break", {31'd0, busy}, 32'd1);
      wait_cycles(stop_low * CPB - 24);
    end
    signal = 1'b1;
    wait_cycles(CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, msg_valid}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_status"}, {24'd0, msg_status}, 32'h00);
    chk({tag, "_d1"}, {24'd0, msg_data1}, 32'h00);
    chk({tag, "_d2"}, {24'd0, msg_data2}, 32'h00);
    chk({tag, "_led"}, {24'd0, LED}, 32'hFF);
  endtask

  initial begin
    wait_cycles(5);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(20);

    // Note-on with latency check on the final byte
    base = n_valid;
    push(8'h90, 8'h3C, 8'h64);
    send_byte(8'h90, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h64, 0);
    wait_cycles(40);
    chk("noteon_count", n_valid - base, 1);
    chk("noteon_latency", last_valid_cyc - last_start, 2 + 1 + CPB / 2 + 9 * CPB);
    chk("noteon_led_hold", {24'd0, LED}, 32'h3C);

    // Program change
    base = n_valid;
    push(8'hC5, 8'h07, 8'h00);
    send_byte(8'hC5, 0);
    send_byte(8'h07, 0);
    wait_cycles(40);
    chk("progchg_count", n_valid - base, 1);

    // Running status
    base = n_valid;
    push(8'h90, 8'h3C, 8'h64);
`ifdef MIDI_RUNNING_STATUS_EN
    push(8'h90, 8'h3C, 8'h00);
`endif
    send_byte(8'h90, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h64, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h00, 0);
    wait_cycles(40);
`ifdef MIDI_RUNNING_STATUS_EN
    chk("runstat_count", n_valid - base, 2);
`else
    chk("runstat_count", n_valid - base, 1);
`endif

    // Realtime byte interleaved mid-message
    base = n_valid;
    push(8'h90, 8'h3C, 8'h64);
    send_byte(8'h90, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hF8, 0);
    send_byte(8'h64, 0);
    wait_cycles(40);
    chk("realtime_count", n_valid - base, 1);

    // Framing error, then recovery
    base = n_ferr;
    send_byte(8'h90, 0);
    send_byte(8'h3C, 3);
    chk("ferr_count", n_ferr - base, 1);
    chk("busy_after_break", {31'd0, busy}, 32'd0);
    base = n_valid;
    push(8'h80, 8'h40, 8'h00);
    send_byte(8'h80, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    wait_cycles(40);
    chk("after_ferr_count", n_valid - base, 1);

    // 4-clock glitch
    base = n_valid;
    signal = 1'b0;
    wait_cycles(4);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    signal = 1'b1;
    for (int i = 0; i < 9 && busy; i++) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    wait_cycles(200);
    chk("glitch_count", n_valid - base, 0);

    // Reset pulse during bit 4 of 0x90 (bits LSB first: 0,0,0,0,1,0,0,1)
    signal = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      signal = 1'b0;
      wait_cycles(CPB);
    end
    signal = 1'b1;
    wait_cycles(8);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    chk_reset_outputs("midreset");
    wait_cycles(CPB - 9);
    signal = 1'b0;
    wait_cycles(2 * CPB);
    signal = 1'b1;
    wait_cycles(2 * CPB);
    wait_cycles(20 * CPB);
    base = n_valid;
    push(8'h90, 8'h3C, 8'h64);
    send_byte(8'h90, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h64, 0);
    wait_cycles(40);
    chk("postreset_count", n_valid - base, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
